// File: rtl/sram_test_seq_pkg.sv
// rtl/sram_test_seq_pkg.sv - shared encodings for the sram_ctrl write/readback sequencer
package sram_test_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_CFG, S_ARM, S_WAIT, S_CHK, S_NEXT, S_DONE
  } seq_state_e;

  // sram_ctrl one-hot state codes as seen on status[7:0]
  localparam logic [7:0] ST_CONFIG = 8'h01;
  localparam logic [7:0] ST_IDLE   = 8'h02;
  localparam logic [7:0] ST_READ   = 8'h04;
  localparam logic [7:0] ST_WRITE  = 8'h08;

  // sram_ctrl command codes carried in enable[2:1]
  localparam logic [1:0] CMD_WR  = 2'b00;
  localparam logic [1:0] CMD_RD  = 2'b01;
  localparam logic [1:0] CMD_UPD = 2'b10;

  // op_cfg bit positions
  localparam int OPC_CYC      = 0;
  localparam int OPC_DEC      = 1;
  localparam int OPC_DIRECT   = 2;
  localparam int OPC_JUMP_LSB = 22;
  localparam int OPC_JUMP_MSB = 31;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0
  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

endpackage

// File: rtl/sram_test_seq_if.sv
// rtl/sram_test_seq_if.sv - register-level link between the sequencer and sram_ctrl
interface sram_test_seq_if;
  logic [31:0] enable;
  logic [31:0] send;
  logic [31:0] sta_addr;
  logic [31:0] area_cfg;
  logic [31:0] op_cfg;
  logic [31:0] outp_data;
  logic [31:0] status;

  modport master (output enable, send, sta_addr, area_cfg, op_cfg,
                  input  outp_data, status);
  modport slave  (input  enable, send, sta_addr, area_cfg, op_cfg,
                  output outp_data, status);
endinterface

// File: rtl/sram_pat_gen.sv
// rtl/sram_pat_gen.sv - per-address test pattern generator with reseedable LFSR
module sram_pat_gen
  import sram_test_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        pat_sel,
  input  logic [ADDR_W-1:0] addr,
  input  logic              lfsr_step,
  input  logic              lfsr_init,
  output logic [DATA_W-1:0] pattern
);

  logic [7:0] lfsr_q, lfsr_d;
  logic [7:0] addr8;
  logic [7:0] pat8;

  assign addr8 = 8'(addr);

  // reseed at each phase start so write and read phases see the same sequence
  always_comb begin
    lfsr_d = lfsr_q;
    if (lfsr_init)      lfsr_d = LFSR_SEED;
    else if (lfsr_step) lfsr_d = lfsr_next(lfsr_q);
  end

  // LFSR state register
  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end

  // pattern select
  always_comb begin
    pat8 = addr8;
    case (pat_sel)
      2'd0: pat8 = addr8;
      2'd1: pat8 = addr8[0] ? 8'hAA : 8'h55;
      2'd2: pat8 = ~addr8;
      2'd3: pat8 = lfsr_q;
      default: pat8 = addr8;
    endcase
  end

  assign pattern = DATA_W'(pat8);

endmodule

// File: rtl/sram_test_seq.sv
// rtl/sram_test_seq.sv - write-then-readback sequencer for sram_ctrl; SEQ_ERRLOG_EN adds first-mismatch log
module sram_test_seq
  import sram_test_seq_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 10,
  parameter int CFG_CYC = 2,
  parameter int TMO_CYC = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [1:0]        pat_sel,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [15:0]       err_cnt,
`ifdef SEQ_ERRLOG_EN
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_act,
`endif
  sram_test_seq_if.master   bus
);

  localparam int CNT_W = $clog2(TMO_CYC + CFG_CYC + 1) + 1;

  seq_state_e        state_q, state_d;
  logic              phase_rd_q, phase_rd_d;
  logic [ADDR_W:0]   idx_q, idx_d, idx_inc;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [1:0]        pat_q, pat_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              seen_q, seen_d;
  logic [15:0]       err_q, err_d;
  logic              tmo_q, tmo_d;
  logic              fin_q, fin_d;
`ifdef SEQ_ERRLOG_EN
  logic [ADDR_W-1:0] faddr_q, faddr_d;
  logic [DATA_W-1:0] fexp_q, fexp_d, fact_q, fact_d;
`endif

  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] pattern;
  logic [DATA_W-1:0] rd_data;
  logic [7:0]        status8, op_state;
  logic              lfsr_init, lfsr_step, op_active;
  logic [1:0]        cmd;
  logic              unused_in;

  assign cur_addr  = base_q + idx_q[ADDR_W-1:0];
  assign idx_inc   = idx_q + 1'b1;
  assign status8   = bus.status[7:0];
  assign rd_data   = bus.outp_data[DATA_W-1:0];
  assign op_state  = phase_rd_q ? ST_READ : ST_WRITE;
  assign cmd       = phase_rd_q ? CMD_RD : CMD_WR;
  assign op_active = (state_q == S_ARM) || (state_q == S_WAIT);
  assign unused_in = ^{bus.outp_data[31:DATA_W], bus.status[31:8]};

  sram_pat_gen #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_pat (
    .clk       (clk),
    .reset     (reset),
    .pat_sel   (pat_q),
    .addr      (cur_addr),
    .lfsr_step (lfsr_step),
    .lfsr_init (lfsr_init),
    .pattern   (pattern)
  );

  // next-state and datapath updates; cnt counts cycles spent in the current state
  always_comb begin
    state_d    = state_q;
    phase_rd_d = phase_rd_q;
    idx_d      = idx_q;
    base_d     = base_q;
    len_d      = len_q;
    pat_d      = pat_q;
    seen_d     = seen_q;
    err_d      = err_q;
    tmo_d      = tmo_q;
    fin_d      = fin_q;
    lfsr_init  = 1'b0;
    lfsr_step  = 1'b0;
`ifdef SEQ_ERRLOG_EN
    faddr_d = faddr_q;
    fexp_d  = fexp_q;
    fact_d  = fact_q;
`endif
    case (state_q)
      S_IDLE: if (start) begin
        base_d     = base_addr;
        len_d      = length;
        pat_d      = pat_sel;
        err_d      = '0;
        tmo_d      = 1'b0;
        fin_d      = 1'b0;
        phase_rd_d = 1'b0;
        idx_d      = '0;
        lfsr_init  = 1'b1;
`ifdef SEQ_ERRLOG_EN
        faddr_d = '0;
        fexp_d  = '0;
        fact_d  = '0;
`endif
        state_d = (length == '0) ? S_DONE : S_CFG;
      end
      S_CFG: if (cnt_q == CNT_W'(CFG_CYC - 1)) state_d = S_ARM;
      S_ARM: begin
        seen_d  = 1'b0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // an IDLE before the op state is sram_ctrl leaving CONFIG, not completion
        if (status8 == op_state) seen_d = 1'b1;
        if (seen_q && status8 == ST_IDLE) begin
          state_d = phase_rd_q ? S_CHK : S_NEXT;
        end else if (cnt_q == CNT_W'(TMO_CYC - 1)) begin
          tmo_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_CHK: begin
        if (rd_data != pattern) begin
          if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
`ifdef SEQ_ERRLOG_EN
          if (err_q == 16'd0) begin
            faddr_d = cur_addr;
            fexp_d  = pattern;
            fact_d  = rd_data;
          end
`endif
        end
        state_d = S_NEXT;
      end
      S_NEXT: begin
        lfsr_step = 1'b1;
        if (idx_inc == len_q) begin
          if (!phase_rd_q) begin
            phase_rd_d = 1'b1;
            idx_d      = '0;
            lfsr_init  = 1'b1;
            state_d    = S_CFG;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          idx_d   = idx_inc;
          state_d = S_CFG;
        end
      end
      S_DONE: begin
        fin_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
  end

  // state and datapath registers; reset aborts any run on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      phase_rd_q <= 1'b0;
      idx_q      <= '0;
      base_q     <= '0;
      len_q      <= '0;
      pat_q      <= '0;
      cnt_q      <= '0;
      seen_q     <= 1'b0;
      err_q      <= '0;
      tmo_q      <= 1'b0;
      fin_q      <= 1'b0;
`ifdef SEQ_ERRLOG_EN
      faddr_q <= '0;
      fexp_q  <= '0;
      fact_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      phase_rd_q <= phase_rd_d;
      idx_q      <= idx_d;
      base_q     <= base_d;
      len_q      <= len_d;
      pat_q      <= pat_d;
      cnt_q      <= cnt_d;
      seen_q     <= seen_d;
      err_q      <= err_d;
      tmo_q      <= tmo_d;
      fin_q      <= fin_d;
`ifdef SEQ_ERRLOG_EN
      faddr_q <= faddr_d;
      fexp_q  <= fexp_d;
      fact_q  <= fact_d;
`endif
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign pass    = (done || fin_q) && (err_q == 16'd0) && !tmo_q;
  assign timeout = tmo_q;
  assign err_cnt = err_q;
`ifdef SEQ_ERRLOG_EN
  assign fail_addr = faddr_q;
  assign fail_exp  = fexp_q;
  assign fail_act  = fact_q;
`endif

  // enable[0]=0 outside ARM/WAIT holds sram_ctrl in CONFIG so it reloads cfg
  assign bus.enable   = op_active ? {29'd0, cmd, 1'b1} : 32'd0;
  assign bus.send     = !op_active ? 32'd0 :
                        (phase_rd_q ? 32'(cur_addr) : 32'(pattern));
  assign bus.sta_addr = busy ? 32'(cur_addr) : 32'd0;
  assign bus.area_cfg = 32'd0;
  assign bus.op_cfg   = (busy && phase_rd_q) ? (32'd1 << OPC_DIRECT) : 32'd0;

endmodule
